// File: rtl/pc_sequencer_if.sv
// ============================================================================
//  Module   : pc_sequencer_if
//  Purpose  : Bundles the fetch-stage signals shared by the PC sequencer, the
//             instruction memory, the decode/execute redirect sources and the
//             IF/ID pipeline register.
//  Modports : master - the PC sequencer (drives requests and fetch results)
//             slave  - the surrounding pipeline / memory side
//  Signals  : stall, imem_req/imem_addr/imem_ready, redirect_pc_plus4,
//             branch_valid/branch_taken/branch_imm, jump_valid/jump_index,
//             fetch_valid/fetch_pc/fetch_pc_plus4, squash
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_sequencer_if;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] redirect_pc_plus4;
    logic        branch_valid;
    logic        branch_taken;
    logic [31:0] branch_imm;
    logic        jump_valid;
    logic [25:0] jump_index;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_plus4;
    logic        squash;

    modport master (
        input  stall, imem_ready, redirect_pc_plus4, branch_valid, branch_taken,
               branch_imm, jump_valid, jump_index,
        output imem_req, imem_addr, fetch_valid, fetch_pc, fetch_pc_plus4, squash
    );

    modport slave (
        output stall, imem_ready, redirect_pc_plus4, branch_valid, branch_taken,
               branch_imm, jump_valid, jump_index,
        input  imem_req, imem_addr, fetch_valid, fetch_pc, fetch_pc_plus4, squash
    );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Fetch-stage controller. Owns the program counter, issues
//             instruction-memory requests over a req/ready handshake, applies
//             taken-branch and jump redirects, honours decode stalls and
//             squashes any fetch that a redirect overtakes.
//  Ports    : clk   - rising-edge clock
//             reset - asynchronous active-high reset
//             bus   - pc_sequencer_if.master (memory, redirect, IF/ID signals)
//  Params   : RESET_PC - PC loaded on reset (low two bits forced to 0)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  wire logic        clk,
    input  wire logic        reset,
    pc_sequencer_if.master   bus
);

    localparam logic [31:0] c_reset_pc = {RESET_PC[31:2], 2'b00};

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic        r_pend_valid;
    logic [31:0] r_pend_target;
    logic        r_fetch_valid;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_fetch_pc_plus4;
    logic        r_squash;

    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;
    logic [31:0] w_target;
    logic        w_redirect;

    // Word-aligned base plus the word offset; bits beyond 32 simply wrap.
    assign w_branch_target = {bus.redirect_pc_plus4[31:2], 2'b00}
                           + {bus.branch_imm[29:0], 2'b00};
    assign w_jump_target   = {bus.redirect_pc_plus4[31:28], bus.jump_index, 2'b00};
    // A jump outranks a branch resolved in the same cycle.
    assign w_target        = bus.jump_valid ? w_jump_target : w_branch_target;
    assign w_redirect      = bus.jump_valid | (bus.branch_valid & bus.branch_taken);

    // Bits that do not contribute to any target.
    logic w_unused_bits;
    assign w_unused_bits = ^{bus.redirect_pc_plus4[1:0], bus.branch_imm[31:30]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_pc             <= c_reset_pc;
            r_pend_valid     <= 1'b0;
            r_pend_target    <= 32'h0;
            r_fetch_valid    <= 1'b0;
            r_fetch_pc       <= 32'h0;
            r_fetch_pc_plus4 <= 32'h0;
            r_squash         <= 1'b0;
        end else begin
            r_fetch_valid <= 1'b0;
            r_squash      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_redirect) begin
                        r_pc     <= w_target;
                        r_squash <= 1'b1;
                    end
                    if (!bus.stall) begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!bus.imem_ready) begin
                        // Request must stay stable; remember the newest redirect.
                        if (w_redirect) begin
                            r_pend_target <= w_target;
                            r_pend_valid  <= 1'b1;
                        end
                    end else begin
                        if (w_redirect || r_pend_valid) begin
                            // Accepted fetch is on the wrong path: drop it.
                            r_pc     <= w_redirect ? w_target : r_pend_target;
                            r_squash <= 1'b1;
                        end else begin
                            r_fetch_valid    <= 1'b1;
                            r_fetch_pc       <= r_pc;
                            r_fetch_pc_plus4 <= r_pc + 32'd4;
                            r_pc             <= r_pc + 32'd4;
                        end
                        r_pend_valid <= 1'b0;
                        r_state      <= bus.stall ? S_IDLE : S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Driven straight from the state register so reset drops the request at once.
    assign bus.imem_req       = (r_state == S_REQ);
    assign bus.imem_addr      = r_pc;
    assign bus.fetch_valid    = r_fetch_valid;
    assign bus.fetch_pc       = r_fetch_pc;
    assign bus.fetch_pc_plus4 = r_fetch_pc_plus4;
    assign bus.squash         = r_squash;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
//  Module   : tb_pc_sequencer
//  Purpose  : Self-checking bench for pc_sequencer: directed scenarios with
//             literal expectations followed by randomized traffic compared
//             every cycle against a transaction-level fetch model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    localparam logic [31:0] c_rst_pc = 32'h0040_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;

    pc_sequencer_if bus();

    pc_sequencer #(.RESET_PC(c_rst_pc)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an outstanding-request flag, the address being fetched, the
    // newest redirect seen while the request waits, and the last delivery.
    logic        m_busy;
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_pend_tgt;
    logic        m_fv;
    logic        m_sq;
    logic [31:0] m_fpc;
    logic [31:0] m_fpc4;

    task automatic m_reset();
        m_busy = 1'b0; m_pc = c_rst_pc; m_pend = 1'b0; m_pend_tgt = 32'h0;
        m_fv = 1'b0; m_sq = 1'b0; m_fpc = 32'h0; m_fpc4 = 32'h0;
    endtask

    task automatic model_step();
        logic        ev;
        logic [31:0] tgt;
        ev = bus.jump_valid || (bus.branch_valid && bus.branch_taken);
        if (bus.jump_valid)
            tgt = (bus.redirect_pc_plus4 & 32'hF000_0000) | (32'(bus.jump_index) * 32'd4);
        else
            tgt = (bus.redirect_pc_plus4 & ~32'h3) + bus.branch_imm * 32'd4;
        m_fv = 1'b0;
        m_sq = 1'b0;
        if (!m_busy) begin
            if (ev) begin m_pc = tgt; m_sq = 1'b1; end
            m_busy = !bus.stall;
        end else if (!bus.imem_ready) begin
            if (ev) begin m_pend = 1'b1; m_pend_tgt = tgt; end
        end else begin
            if (ev || m_pend) begin
                m_pc = ev ? tgt : m_pend_tgt;
                m_sq = 1'b1;
            end else begin
                m_fv = 1'b1; m_fpc = m_pc; m_fpc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
            end
            m_pend = 1'b0;
            m_busy = !bus.stall;
        end
    endtask

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        if (reset) m_reset();
        else       model_step();
        #1;
        check("imem_req",       32'(bus.imem_req),       32'(m_busy));
        check("imem_addr",      bus.imem_addr,           m_pc);
        check("fetch_valid",    32'(bus.fetch_valid),    32'(m_fv));
        check("squash",         32'(bus.squash),         32'(m_sq));
        check("fetch_pc",       bus.fetch_pc,            m_fpc);
        check("fetch_pc_plus4", bus.fetch_pc_plus4,      m_fpc4);
        check("fv_sq_excl",     32'(bus.fetch_valid & bus.squash), 32'h0);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_redirects();
        bus.branch_valid = 1'b0; bus.branch_taken = 1'b0; bus.jump_valid = 1'b0;
    endtask

    logic [31:0] r32;
    logic [15:0] r16;

    initial begin
        bus.stall = 1'b0; bus.imem_ready = 1'b1; bus.redirect_pc_plus4 = 32'h0;
        bus.branch_imm = 32'h0; bus.jump_index = 26'h0;
        clear_redirects();
        m_reset();
        tick(); tick();
        check("rst_req",   32'(bus.imem_req), 32'h0);
        check("rst_addr",  bus.imem_addr, c_rst_pc);
        check("rst_fv",    32'(bus.fetch_valid), 32'h0);
        check("rst_fpc4",  bus.fetch_pc_plus4, 32'h0);
        check("rst_sq",    32'(bus.squash), 32'h0);

        // Free-running fetch.
        reset = 1'b0;
        tick(); check("run_req", 32'(bus.imem_req), 32'h1); check("run_a0", bus.imem_addr, 32'h0040_0000);
        tick(); check("run_a1", bus.imem_addr, 32'h0040_0004); check("run_fv1", 32'(bus.fetch_valid), 32'h1);
                check("run_fpc1", bus.fetch_pc, 32'h0040_0000); check("run_fp4", bus.fetch_pc_plus4, 32'h0040_0004);
        tick(); check("run_a2", bus.imem_addr, 32'h0040_0008); check("run_fpc2", bus.fetch_pc, 32'h0040_0004);

        // Branch while idle.
        bus.stall = 1'b1;
        tick(); check("stall_idle_req", 32'(bus.imem_req), 32'h0);
        bus.branch_valid = 1'b1; bus.branch_taken = 1'b1;
        bus.redirect_pc_plus4 = 32'h0040_0010; bus.branch_imm = 32'hFFFF_FFFC;
        tick(); check("idle_br_addr", bus.imem_addr, 32'h0040_0000); check("idle_br_sq", 32'(bus.squash), 32'h1);
        bus.branch_taken = 1'b0;
        tick(); check("idle_nt_addr", bus.imem_addr, 32'h0040_0000); check("idle_nt_sq", 32'(bus.squash), 32'h0);
        clear_redirects();

        // Jump while the request waits three cycles for ready.
        bus.stall = 1'b0; bus.imem_ready = 1'b0;
        tick(); check("wait_req", 32'(bus.imem_req), 32'h1);
        bus.jump_valid = 1'b1; bus.redirect_pc_plus4 = 32'h1000_0000; bus.jump_index = 26'h000_0100;
        tick(); check("wait_hold", bus.imem_addr, 32'h0040_0000);
        clear_redirects();
        tick(); tick();
        bus.imem_ready = 1'b1;
        tick(); check("jmp_addr", bus.imem_addr, 32'h1000_0400); check("jmp_sq", 32'(bus.squash), 32'h1);
                check("jmp_fv", 32'(bus.fetch_valid), 32'h0);

        // Newer branch overrides the pending jump.
        bus.imem_ready = 1'b0; bus.jump_valid = 1'b1;
        tick();
        clear_redirects();
        bus.branch_valid = 1'b1; bus.branch_taken = 1'b1;
        bus.redirect_pc_plus4 = 32'h0040_0010; bus.branch_imm = 32'hFFFF_FFFC;
        tick();
        clear_redirects(); bus.imem_ready = 1'b1;
        tick(); check("ovr_addr", bus.imem_addr, 32'h0040_0000); check("ovr_sq", 32'(bus.squash), 32'h1);

        // Jump and taken branch together on the acceptance cycle.
        bus.jump_valid = 1'b1; bus.branch_valid = 1'b1; bus.branch_taken = 1'b1;
        bus.redirect_pc_plus4 = 32'h1000_0000; bus.jump_index = 26'h000_0100;
        tick(); check("both_addr", bus.imem_addr, 32'h1000_0400); check("both_fv", 32'(bus.fetch_valid), 32'h0);
        clear_redirects();
        tick(); check("both_one_sq", 32'(bus.squash), 32'h0); check("both_fpc", bus.fetch_pc, 32'h1000_0400);

        // Stall while ready is low: request held, then back to idle.
        bus.imem_ready = 1'b0; bus.stall = 1'b1;
        tick(); tick(); check("sw_req", 32'(bus.imem_req), 32'h1); check("sw_addr", bus.imem_addr, 32'h1000_0404);
        bus.imem_ready = 1'b1;
        tick(); check("sw_fpc", bus.fetch_pc, 32'h1000_0404); check("sw_idle", 32'(bus.imem_req), 32'h0);
        bus.stall = 1'b0;
        tick(); check("sw_restart", bus.imem_addr, 32'h1000_0408);

        // PC wrap-around.
        bus.jump_valid = 1'b1; bus.redirect_pc_plus4 = 32'hF000_0000; bus.jump_index = 26'h3FF_FFFF;
        tick(); check("wrap_top", bus.imem_addr, 32'hFFFF_FFFC);
        clear_redirects();
        tick(); check("wrap_addr", bus.imem_addr, 32'h0000_0000); check("wrap_fp4", bus.fetch_pc_plus4, 32'h0000_0000);

        // Asynchronous reset with a pending redirect.
        bus.imem_ready = 1'b0;
        tick();
        bus.jump_valid = 1'b1; bus.redirect_pc_plus4 = 32'h1000_0000; bus.jump_index = 26'h000_0100;
        tick();
        clear_redirects();
        #1 reset = 1'b1; m_reset();
        #1 check("arst_req", 32'(bus.imem_req), 32'h0); check("arst_addr", bus.imem_addr, c_rst_pc);
        bus.imem_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick(); check("arst_rel_addr", bus.imem_addr, c_rst_pc); check("arst_rel_sq", 32'(bus.squash), 32'h0);
        tick(); check("arst_fpc", bus.fetch_pc, c_rst_pc); check("arst_sq2", 32'(bus.squash), 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bus.stall        = ($urandom % 4) == 0;
            bus.imem_ready   = ($urandom % 3) != 0;
            bus.branch_valid = ($urandom % 4) == 0;
            bus.branch_taken = $urandom % 2;
            bus.jump_valid   = ($urandom % 8) == 0;
            bus.redirect_pc_plus4 = $urandom;
            r16 = 16'($urandom);
            bus.branch_imm   = {{16{r16[15]}}, r16};
            r32 = $urandom;
            bus.jump_index   = r32[25:0];
            if (($urandom % 300) == 0) begin
                reset = 1'b1; m_reset();
                tick();
                reset = 1'b0;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage controller that owns the program counter and sequences the PC+4 and branch-target arithmetic. It issues instruction-memory requests over a req/ready handshake, applies taken-branch and jump redirects, and honours decode stalls. It squashes any fetch that a redirect overtakes. It sits between the IF/ID pipeline register and instruction memory, and replaces free-running PC update logic.

## Interface
- RESET_PC, 32'h0040_0000, PC value loaded on reset (bits [1:0] must be 0)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- stall  in  1  decode stall; blocks issue of a new fetch request
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address; equals pc, stable while imem_req=1
- imem_ready  in  1  memory accepts the request this cycle when imem_req=1
- redirect_pc_plus4  in  32  PC+4 of the branch/jump instruction; bits [1:0] ignored
- branch_valid  in  1  branch resolved this cycle
- branch_taken  in  1  branch outcome; qualified by branch_valid
- branch_imm  in  32  sign-extended 16-bit immediate
- jump_valid  in  1  J/JAL resolved this cycle
- jump_index  in  26  instruction index field
- fetch_valid  out  1  registered pulse: an accepted fetch is delivered to IF/ID
- fetch_pc  out  32  PC of the delivered fetch
- fetch_pc_plus4  out  32  fetch_pc + 4, modulo 2^32
- squash  out  1  registered one-cycle pulse after a redirect is applied; flushes IF/ID

## Operation
- Registers: pc[31:0], state {IDLE, REQ}, pend_valid, pend_target[31:0], plus registered outputs.
- Branch target: {redirect_pc_plus4[31:2],2'b00} + (branch_imm << 2), truncated to 32 bits. Wrap-around is legal.
- Jump target: {redirect_pc_plus4[31:28], jump_index, 2'b00}.
- Redirect event: jump_valid=1, or branch_valid=1 with branch_taken=1.
  - If jump_valid and branch_valid are both 1, the jump wins.
  - branch_valid=1 with branch_taken=0 is not an event.
- IDLE: imem_req=0.
  - A redirect event sets pc to the target next cycle and pulses squash.
  - stall=0 moves to REQ next cycle.
- REQ: imem_req=1, imem_addr=pc. Address and req are held until imem_ready=1.
- REQ, imem_ready=0, redirect event: latch pend_target and set pend_valid. A later redirect overwrites it (newest wins).
- REQ, imem_ready=1, with a redirect event this cycle or pend_valid=1:
  - The fetch is squashed: fetch_valid stays 0.
  - pc takes the target. A same-cycle event beats pending.
  - pend_valid clears and squash pulses.
- REQ, imem_ready=1, otherwise: fetch_valid=1 next cycle with fetch_pc=pc, and pc advances to pc+4 (mod 2^32).
- Exit from REQ after acceptance: REQ if stall=0, else IDLE. Without acceptance, stay in REQ regardless of stall; an issued request is never withdrawn.
- Stall never blocks redirect capture or application.
- imem_addr[1:0] is always 00.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, fetch_valid=0, fetch_pc=0, fetch_pc_plus4=0, squash=0, pend_valid=0.
- Reset mid-request drops imem_req immediately (asynchronous) and discards any pending redirect.
- First request: the first cycle after reset release with stall=0 is IDLE; imem_req rises the following cycle.
- Latency: fetch_valid rises 1 cycle after the imem_ready handshake. A redirect in IDLE or on the acceptance cycle is reflected on imem_addr 1 cycle later.
- Throughput: 1 fetch/cycle when stall=0 and imem_ready=1 continuously.
- fetch_valid and squash are never both 1 in the same cycle.

## Test plan
- Reset, stall=0, imem_ready=1 constant:
  - imem_addr runs 0x00400000, 0x00400004, 0x00400008.
  - fetch_valid=1 every cycle from the 3rd cycle after release.
  - fetch_pc_plus4 = fetch_pc+4.
- Branch in IDLE: redirect_pc_plus4=0x00400010, branch_imm=0xFFFFFFFC, taken → next pc=0x00400000, squash pulse, no fetch_valid. Same inputs with branch_taken=0 → pc unchanged, no squash.
- Jump during a REQ stalled by imem_ready=0 for 3 cycles: redirect_pc_plus4=0x10000000, jump_index=0x0000100 → the accepted fetch is squashed and the next imem_addr is 0x10000400. A second branch arriving before acceptance overrides it.
- Simultaneous jump_valid and taken branch on the acceptance cycle → the jump target wins, exactly one squash pulse, fetch_valid=0.
- stall=1 asserted while imem_ready=0 → imem_req and imem_addr stay held until ready, then return to IDLE with imem_req=0; deasserting stall restarts fetch at pc+4. Also pc=0xFFFFFFFC advancing → next pc 0x00000000.
- Async reset asserted mid-REQ with pend_valid=1 → imem_req=0 the same cycle; after release, fetch restarts at RESET_PC with no squash.
